// File: rtl/sample_framer_pkg.sv
// Shared types and constants for the sample framer.
//   framer_state_t   : packet-parsing FSM states
//   BYTE_W           : width of one incoming byte
//   bytes_per_sample : number of bytes that make up one WIDTH-bit sample
package sample_framer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_LEN  = 2'd1,
    COLLECT  = 2'd2,
    FIN_HOLD = 2'd3
  } framer_state_t;

  function automatic int unsigned bytes_per_sample(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/sample_framer_byte_assembler.sv
// Assembles little-endian WIDTH-bit samples from a byte stream.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   byte_in        : incoming byte
//   byte_valid     : byte_in is valid this cycle
//   clear          : drop any partially assembled sample
//   sample_valid_c : combinational, high on the cycle the completing byte arrives
//   sample_c       : combinational, the completed sample (valid with sample_valid_c)
module byte_assembler
  import sample_framer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             clear,
  output logic             sample_valid_c,
  output logic [WIDTH-1:0] sample_c
);

  localparam int unsigned BPS   = bytes_per_sample(WIDTH);
  localparam int unsigned CNT_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_buf;
  logic [IDX_W-1:0] w_base;

  assign w_base = IDX_W'(int'(r_cnt) * int'(BYTE_W));

  // Earlier bytes are parked at their final bit position; the last byte
  // bypasses the register so the sample is usable on its arrival cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (byte_valid) begin
      r_buf[w_base +: BYTE_W] <= byte_in;
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    sample_c = r_buf;
    sample_c[WIDTH-BYTE_W +: BYTE_W] = byte_in;
  end

  assign sample_valid_c = byte_valid && !clear && (r_cnt == LAST);

endmodule

// File: rtl/sample_framer.sv
// Length-prefixed packet parser feeding the range-finding stage.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   byte_in      : incoming data byte
//   byte_valid   : byte_in valid this cycle
//   start        : request to begin a packet
//   abort        : request to terminate the current packet
//   data_out     : current sample, held between samples
//   go           : one-cycle pulse with the first sample
//   finish       : one-cycle pulse marking the end of a packet
//   busy         : high from accepted start until the cycle after finish
//   frame_error  : sticky protocol-error flag, cleared by an accepted start
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             frame_error
);

  framer_state_t    r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_go;
  logic             r_finish;
  logic             r_busy;
  logic             r_err;

  logic             w_asm_valid;
  logic             w_asm_clear;
  logic             w_sample_valid;
  logic [WIDTH-1:0] w_sample;
  logic [LEN_W-1:0] w_cnt_next;

  // Bytes only reach the assembler while collecting; abort discards them.
  assign w_asm_valid = byte_valid && (r_state == COLLECT) && !abort;
  assign w_asm_clear = (r_state != COLLECT) || abort;
  assign w_cnt_next  = r_cnt + LEN_W'(1);

  byte_assembler #(
    .WIDTH (WIDTH)
  ) u_asm (
    .clock          (clock),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_valid     (w_asm_valid),
    .clear          (w_asm_clear),
    .sample_valid_c (w_sample_valid),
    .sample_c       (w_sample)
  );

  // Packet FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      case (r_state)
        IDLE: begin
          // Also drops busy the cycle after a finish pulse.
          r_busy <= start;
          if (start) begin
            r_state <= GET_LEN;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
          end
        end

        GET_LEN: begin
          if (start) r_err <= 1'b1;
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (byte_valid) begin
            if (byte_in == 8'd0) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_len   <= LEN_W'(byte_in);
              r_state <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (start) r_err <= 1'b1;
          if (abort) begin
            r_state <= IDLE;
            // Once go is out the downstream needs a closing finish.
            if (r_cnt != '0) begin
              r_finish <= 1'b1;
              r_err    <= 1'b1;
            end else begin
              r_busy <= 1'b0;
            end
          end else if (w_sample_valid) begin
            r_data <= w_sample;
            r_cnt  <= w_cnt_next;
            if (r_cnt == '0) begin
              r_go <= 1'b1;
              // Single-sample packet: finish goes out a cycle later.
              if (r_len == LEN_W'(1)) r_state <= FIN_HOLD;
            end else if (w_cnt_next == r_len) begin
              r_finish <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end

        FIN_HOLD: begin
          if (start) r_err <= 1'b1;
          r_finish <= 1'b1;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out    = r_data;
  assign go          = r_go;
  assign finish      = r_finish;
  assign busy        = r_busy;
  assign frame_error = r_err;

endmodule

// File: tb/tb_sample_framer.sv
// Directed self-checking bench for sample_framer (WIDTH=16).
module tb_sample_framer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] data_out;
  logic        go;
  logic        finish;
  logic        busy;
  logic        frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int go_n = 0;
  int fin_n = 0;
  int both_n = 0;
  int g0;
  int f0;

  sample_framer #(
    .WIDTH (16),
    .LEN_W (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .start       (start),
    .abort       (abort),
    .data_out    (data_out),
    .go          (go),
    .finish      (finish),
    .busy        (busy),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  // Pulse tally, sampled mid-cycle.
  always @(negedge clock) begin
    if (go) go_n = go_n + 1;
    if (finish) fin_n = fin_n + 1;
    if (go && finish) both_n = both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_go", 32'(go), 32'h0);
    chk("rst_finish", 32'(finish), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(frame_error), 32'h0);

    // N=3 packet
    g0 = go_n; f0 = fin_n;
    pulse_start();
    chk("t1_busy_start", 32'(busy), 32'h1);
    send(8'h03); send(8'h02); send(8'h01);
    chk("t1_go", 32'(go), 32'h1);
    chk("t1_go_data", 32'(data_out), 32'h0102);
    chk("t1_go_nofin", 32'(finish), 32'h0);
    send(8'h0B);
    chk("t1_go_drop", 32'(go), 32'h0);
    chk("t1_hold1", 32'(data_out), 32'h0102);
    send(8'h0A);
    chk("t1_s2_data", 32'(data_out), 32'h0A0B);
    send(8'hFF); send(8'h00);
    chk("t1_finish", 32'(finish), 32'h1);
    chk("t1_fin_data", 32'(data_out), 32'h00FF);
    chk("t1_busy_fin", 32'(busy), 32'h1);
    tick();
    chk("t1_busy_after", 32'(busy), 32'h0);
    chk("t1_fin_drop", 32'(finish), 32'h0);
    chk("t1_hold_end", 32'(data_out), 32'h00FF);
    chk("t1_go_cnt", 32'(go_n - g0), 32'd1);
    chk("t1_fin_cnt", 32'(fin_n - f0), 32'd1);

    // N=1 packet
    g0 = go_n; f0 = fin_n;
    pulse_start();
    send(8'h01); send(8'h34); send(8'h12);
    chk("t2_go", 32'(go), 32'h1);
    chk("t2_go_nofin", 32'(finish), 32'h0);
    chk("t2_go_data", 32'(data_out), 32'h1234);
    tick();
    chk("t2_finish", 32'(finish), 32'h1);
    chk("t2_fin_nogo", 32'(go), 32'h0);
    chk("t2_fin_data", 32'(data_out), 32'h1234);
    tick();
    chk("t2_busy_after", 32'(busy), 32'h0);
    chk("t2_go_cnt", 32'(go_n - g0), 32'd1);
    chk("t2_fin_cnt", 32'(fin_n - f0), 32'd1);

    // Zero-length packet, error clear, start+abort priority
    g0 = go_n; f0 = fin_n;
    pulse_start();
    send(8'h00);
    chk("t3_err", 32'(frame_error), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    tick();
    chk("t3_go_cnt", 32'(go_n - g0), 32'd0);
    chk("t3_fin_cnt", 32'(fin_n - f0), 32'd0);
    pulse_start();
    chk("t3_err_clr", 32'(frame_error), 32'h0);
    chk("t3_busy_re", 32'(busy), 32'h1);
    pulse_abort();
    chk("t3_abort_len", 32'(busy), 32'h0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t3_start_wins", 32'(busy), 32'h1);
    pulse_abort();
    chk("t3_abort2", 32'(busy), 32'h0);
    chk("t3_nopulse", 32'(fin_n - f0), 32'd0);

    // N=4 aborted after sample 2 plus one byte
    g0 = go_n; f0 = fin_n;
    pulse_start();
    send(8'h04); send(8'h11); send(8'h22);
    chk("t4_go_data", 32'(data_out), 32'h2211);
    send(8'h33); send(8'h44);
    chk("t4_s2_data", 32'(data_out), 32'h4433);
    send(8'h55);
    pulse_abort();
    chk("t4_finish", 32'(finish), 32'h1);
    chk("t4_fin_data", 32'(data_out), 32'h4433);
    chk("t4_err", 32'(frame_error), 32'h1);
    tick();
    chk("t4_busy_after", 32'(busy), 32'h0);
    chk("t4_fin_cnt", 32'(fin_n - f0), 32'd1);
    chk("t4_go_cnt", 32'(go_n - g0), 32'd1);

    // Start during COLLECT; packet still completes
    g0 = go_n; f0 = fin_n;
    pulse_start();
    chk("t5_err_clr", 32'(frame_error), 32'h0);
    send(8'h02); send(8'hAA); send(8'hBB);
    chk("t5_go", 32'(go), 32'h1);
    chk("t5_go_data", 32'(data_out), 32'hBBAA);
    pulse_start();
    chk("t5_err", 32'(frame_error), 32'h1);
    chk("t5_busy", 32'(busy), 32'h1);
    send(8'hCC); send(8'hDD);
    chk("t5_finish", 32'(finish), 32'h1);
    chk("t5_fin_data", 32'(data_out), 32'hDDCC);
    chk("t5_err_sticky", 32'(frame_error), 32'h1);
    tick();
    chk("t5_go_cnt", 32'(go_n - g0), 32'd1);
    chk("t5_fin_cnt", 32'(fin_n - f0), 32'd1);

    // Reset mid-COLLECT with gaps, then a clean packet
    pulse_start();
    send(8'h02); send(8'h01); idle(3); send(8'h02);
    chk("t6_go_data", 32'(data_out), 32'h0201);
    send(8'h03); idle(3);
    f0 = fin_n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_data", 32'(data_out), 32'h0);
    chk("t6_rst_go", 32'(go), 32'h0);
    chk("t6_rst_fin", 32'(finish), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_err", 32'(frame_error), 32'h0);
    idle(2);
    chk("t6_no_finish", 32'(fin_n - f0), 32'd0);
    g0 = go_n; f0 = fin_n;
    pulse_start();
    send(8'h02); send(8'h10); send(8'h20);
    chk("t6_new_go", 32'(go), 32'h1);
    chk("t6_new_go_data", 32'(data_out), 32'h2010);
    send(8'h30); send(8'h40);
    chk("t6_new_fin", 32'(finish), 32'h1);
    chk("t6_new_fin_data", 32'(data_out), 32'h4030);
    tick();
    chk("t6_new_busy", 32'(busy), 32'h0);
    chk("t6_new_cnt", 32'(fin_n - f0 + go_n - g0), 32'd2);

    chk("never_coincident", 32'(both_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
